// File: rtl/clock_bcd_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_bcd_cfg_if
//  Description : Button / display bundle between the debounced button block,
//                the BCD clock core and the 7-segment display mux.
//                Alarm signals exist only when CLOCK_ALARM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_bcd_cfg_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       fmt_12h;
    logic [3:0] sec_01;
    logic [3:0] sec_10;
    logic [3:0] min_01;
    logic [3:0] min_10;
    logic [3:0] hour_01;
    logic [3:0] hour_10;
    logic       pm;
    logic       sec_tick;
    logic [2:0] set_state;
`ifdef CLOCK_ALARM_EN
    logic       alarm_on;
    logic       alarm;

    modport master (
        output mode_btn, inc_btn, fmt_12h, alarm_on,
        input  sec_01, sec_10, min_01, min_10, hour_01, hour_10,
        input  pm, sec_tick, set_state, alarm
    );
    modport slave (
        input  mode_btn, inc_btn, fmt_12h, alarm_on,
        output sec_01, sec_10, min_01, min_10, hour_01, hour_10,
        output pm, sec_tick, set_state, alarm
    );
`else
    modport master (
        output mode_btn, inc_btn, fmt_12h,
        input  sec_01, sec_10, min_01, min_10, hour_01, hour_10,
        input  pm, sec_tick, set_state
    );
    modport slave (
        input  mode_btn, inc_btn, fmt_12h,
        output sec_01, sec_10, min_01, min_10, hour_01, hour_10,
        output pm, sec_tick, set_state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/clock_bcd_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_bcd_cfg
//  Description : BCD time-of-day clock with internal 1 s prescaler, two-button
//                set-mode FSM and runtime 12/24 h display selection.
//                Optional alarm enabled by defining CLOCK_ALARM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_bcd_cfg #(
    parameter int CLK_DIV    = 1,
    parameter int ALARM_SECS = 60
) (
    input  wire            clk,
    input  wire            clr_n,
    clock_bcd_cfg_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_HOUR  = 3'd1,
        ST_SET_MIN   = 3'd2,
        ST_SET_AHOUR = 3'd3,
        ST_SET_AMIN  = 3'd4
    } state_t;

    localparam int                 c_PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || ALARM_SECS < 1) begin : g_param_check
        $error("clock_bcd_cfg: CLK_DIV and ALARM_SECS must be at least 1");
    end

    // Packed BCD {tens, units}
    function automatic logic [7:0] f_inc_mod60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] f_inc_hour(input logic [7:0] v);
        if (v == 8'h23) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    state_t             r_state;
    logic [c_PRE_W-1:0] r_pre;
    logic [7:0]         r_sec;
    logic [7:0]         r_min;
    logic [7:0]         r_hour;
    logic               w_tick;
    logic [7:0]         w_hour_disp;
    logic               w_pm;

`ifdef CLOCK_ALARM_EN
    localparam int                  c_ACNT_W    = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [c_ACNT_W-1:0] c_ACNT_LAST = c_ACNT_W'(ALARM_SECS - 1);

    logic [7:0]          r_ahour;
    logic [7:0]          r_amin;
    logic                r_alarm;
    logic [c_ACNT_W-1:0] r_acnt;
    logic                r_tick_q;
    logic                w_alarm_match;
`endif

    assign w_tick = (r_state == ST_RUN) && (r_pre == c_PRE_LAST);

    // Set-mode FSM, prescaler and time-of-day registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_RUN;
            r_pre   <= '0;
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_hour  <= 8'h00;
`ifdef CLOCK_ALARM_EN
            r_ahour <= 8'h00;
            r_amin  <= 8'h00;
`endif
        end else begin
            // Prescaler only runs in RUN; every set state holds it at zero
            if (r_state != ST_RUN) begin
                r_pre <= '0;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        r_pre <= '0;
                        r_sec <= f_inc_mod60(r_sec);
                        if (r_sec == 8'h59) begin
                            r_min <= f_inc_mod60(r_min);
                            if (r_min == 8'h59) begin
                                r_hour <= f_inc_hour(r_hour);
                            end
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                    if (bus.mode_btn) begin
                        r_state <= ST_SET_HOUR;
                        r_pre   <= '0;
                    end
                end
                ST_SET_HOUR: begin
                    if (bus.mode_btn) begin
                        r_state <= ST_SET_MIN;
                    end else if (bus.inc_btn) begin
                        r_hour <= f_inc_hour(r_hour);
                    end
                end
                ST_SET_MIN: begin
                    if (bus.mode_btn) begin
`ifdef CLOCK_ALARM_EN
                        r_state <= ST_SET_AHOUR;
`else
                        // Back to RUN: restart the second from a clean boundary
                        r_state <= ST_RUN;
                        r_sec   <= 8'h00;
`endif
                    end else if (bus.inc_btn) begin
                        r_min <= f_inc_mod60(r_min);
                    end
                end
`ifdef CLOCK_ALARM_EN
                ST_SET_AHOUR: begin
                    if (bus.mode_btn) begin
                        r_state <= ST_SET_AMIN;
                    end else if (bus.inc_btn) begin
                        r_ahour <= f_inc_hour(r_ahour);
                    end
                end
                ST_SET_AMIN: begin
                    if (bus.mode_btn) begin
                        r_state <= ST_RUN;
                        r_sec   <= 8'h00;
                    end else if (bus.inc_btn) begin
                        r_amin <= f_inc_mod60(r_amin);
                    end
                end
`endif
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef CLOCK_ALARM_EN
    // Alarm matches only on the first cycle after a tick lands on hh:mm:00
    assign w_alarm_match = (r_hour == r_ahour) && (r_min == r_amin) && (r_sec == 8'h00);

    // Alarm output: raised on match, held for ALARM_SECS ticks
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_alarm  <= 1'b0;
            r_acnt   <= '0;
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= w_tick;
            if (!bus.alarm_on || (r_state != ST_RUN) || bus.mode_btn) begin
                r_alarm <= 1'b0;
                r_acnt  <= '0;
            end else if (r_alarm) begin
                if (w_tick) begin
                    if (r_acnt == c_ACNT_LAST) begin
                        r_alarm <= 1'b0;
                        r_acnt  <= '0;
                    end else begin
                        r_acnt <= r_acnt + 1'b1;
                    end
                end
            end else if (r_tick_q && w_alarm_match) begin
                r_alarm <= 1'b1;
                r_acnt  <= '0;
            end
        end
    end

    assign bus.alarm = r_alarm;
`endif

    // 12 h view of the 24 h hour register: 00->12, 13..23->01..11
    always_comb begin
        w_hour_disp = r_hour;
        if (bus.fmt_12h) begin
            if (r_hour == 8'h00) begin
                w_hour_disp = 8'h12;
            end else if ((r_hour[7:4] == 4'd1) && (r_hour[3:0] >= 4'd3)) begin
                w_hour_disp = {4'd0, r_hour[3:0] - 4'd2};
            end else if (r_hour[7:4] == 4'd2) begin
                w_hour_disp = (r_hour[3:0] < 4'd2) ? {4'd0, r_hour[3:0] + 4'd8}
                                                   : {4'd1, r_hour[3:0] - 4'd2};
            end
        end
    end

    assign w_pm = (r_hour[7:4] == 4'd2) || ((r_hour[7:4] == 4'd1) && (r_hour[3:0] >= 4'd2));

    assign bus.sec_01    = r_sec[3:0];
    assign bus.sec_10    = r_sec[7:4];
    assign bus.min_01    = r_min[3:0];
    assign bus.min_10    = r_min[7:4];
    assign bus.hour_01   = w_hour_disp[3:0];
    assign bus.hour_10   = w_hour_disp[7:4];
    assign bus.pm        = w_pm;
    assign bus.sec_tick  = w_tick;
    assign bus.set_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clock_bcd_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_bcd_cfg
//  Description : Self-checking bench for clock_bcd_cfg (CLK_DIV=4,
//                ALARM_SECS=3). Alarm checks compiled with CLOCK_ALARM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_bcd_cfg;

    localparam int c_CLK_DIV    = 4;
    localparam int c_ALARM_SECS = 3;
`ifdef CLOCK_ALARM_EN
    localparam logic [2:0] c_POST_MIN = 3'd3;
`else
    localparam logic [2:0] c_POST_MIN = 3'd0;
`endif

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    clock_bcd_cfg_if bus ();

    clock_bcd_cfg #(
        .CLK_DIV    (c_CLK_DIV),
        .ALARM_SECS (c_ALARM_SECS)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] digits();
        return {bus.hour_10, bus.hour_01, bus.min_10, bus.min_01, bus.sec_10, bus.sec_01};
    endfunction

    // One clock cycle with the given button pulses; starts and ends at a negedge
    task automatic step(input bit m, input bit i);
        bus.mode_btn = m;
        bus.inc_btn  = i;
        @(negedge clk);
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    // Starting from 00:00 in RUN, program hh:mm and return to RUN
    task automatic set_time(input int h, input int m);
        step(1, 0);
        repeat (h) step(0, 1);
        step(1, 0);
        repeat (m) step(0, 1);
        step(1, 0);
`ifdef CLOCK_ALARM_EN
        step(1, 0);
        step(1, 0);
`endif
    endtask

`ifdef CLOCK_ALARM_EN
    task automatic set_alarm(input int h, input int m);
        step(1, 0);
        step(1, 0);
        step(1, 0);
        repeat (h) step(0, 1);
        step(1, 0);
        repeat (m) step(0, 1);
        step(1, 0);
    endtask
`endif

    // ---------------- behavioural reference model ----------------
    int m_state;      // 0 RUN, 1 hour, 2 min, 3 alarm hour, 4 alarm min
    int m_secs;       // seconds since midnight
    int m_run_cyc;    // cycles spent in RUN since last (re)start
    int m_ah, m_am;
    bit m_alarm, m_prev_tick;
    int m_acnt;

    task automatic model_reset();
        m_state = 0; m_secs = 0; m_run_cyc = 0;
        m_ah = 0; m_am = 0; m_alarm = 0; m_prev_tick = 0; m_acnt = 0;
    endtask

    function automatic bit m_tick();
        return (m_state == 0) && ((m_run_cyc % c_CLK_DIV) == c_CLK_DIV - 1);
    endfunction

    function automatic logic [28:0] m_expect();
        int h, mi, s, dh;
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
        dh = bus.fmt_12h ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
        return {3'(m_state), 4'(dh / 10), 4'(dh % 10), 4'(mi / 10), 4'(mi % 10),
                4'(s / 10), 4'(s % 10), 1'(h >= 12), 1'(m_tick())};
    endfunction

    task automatic model_step(input bit mode, input bit inc, input bit aon);
        bit tick;
        int h, mi, s;
        tick = m_tick();
        h  = m_secs / 3600;
        mi = (m_secs / 60) % 60;
        s  = m_secs % 60;
`ifdef CLOCK_ALARM_EN
        if (!aon || m_state != 0 || mode) begin
            m_alarm = 0; m_acnt = 0;
        end else if (m_alarm) begin
            if (tick) begin
                if (m_acnt == c_ALARM_SECS - 1) begin m_alarm = 0; m_acnt = 0; end
                else m_acnt++;
            end
        end else if (m_prev_tick && s == 0 && h == m_ah && mi == m_am) begin
            m_alarm = 1; m_acnt = 0;
        end
        m_prev_tick = tick;
`else
        if (aon) m_prev_tick = tick;
`endif
        case (m_state)
            0: begin
                if (tick) m_secs = (m_secs + 1) % 86400;
                m_run_cyc++;
                if (mode) begin m_state = 1; m_run_cyc = 0; end
            end
            1: if (mode) m_state = 2;
               else if (inc) m_secs = ((h + 1) % 24) * 3600 + mi * 60 + s;
            2: if (mode) begin
`ifdef CLOCK_ALARM_EN
                   m_state = 3;
`else
                   m_state = 0; m_secs = m_secs - s; m_run_cyc = 0;
`endif
               end else if (inc) m_secs = h * 3600 + ((mi + 1) % 60) * 60 + s;
            3: if (mode) m_state = 4;
               else if (inc) m_ah = (m_ah + 1) % 24;
            4: if (mode) begin m_state = 0; m_secs = m_secs - s; m_run_cyc = 0; end
               else if (inc) m_am = (m_am + 1) % 60;
            default: m_state = 0;
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         mode;
        bit         inc;
        bit         fmt;
        logic [2:0] st;
        logic [7:0] hr;
        logic [7:0] mn;
        bit         pm;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int seen;
        bit mode, inc, aon;
        logic [28:0] act;

        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        bus.fmt_12h  = 1'b0;
`ifdef CLOCK_ALARM_EN
        bus.alarm_on = 1'b0;
`endif
        tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 3'd1, 8'h12, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 3'd1, 8'h01, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 3'd2, 8'h02, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'h02, 8'h01, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 3'd2, 8'h02, 8'h02, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, c_POST_MIN, 8'h02, 8'h02, 1'b0};

        // Reset state and prescaler cadence
        do_reset();
        chk("reset_digits", digits(), 24'h000000);
        chk("reset_pm", bus.pm, 1'b0);
        chk("reset_state", bus.set_state, 3'd0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("tick_c%0d", k), bus.sec_tick, (k % 4) == 3);
            if (k == 4) chk("first_sec", digits(), 24'h000001);
            @(negedge clk);
        end

        // Table-driven set-mode walk
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.fmt_12h = tbl[i].fmt;
            step(tbl[i].mode, tbl[i].inc);
            chk($sformatf("tbl%0d", i),
                {bus.set_state, bus.hour_10, bus.hour_01, bus.min_10, bus.min_01, bus.pm},
                {tbl[i].st, tbl[i].hr, tbl[i].mn, tbl[i].pm});
        end
        bus.fmt_12h = 1'b0;

        // 23:59:00 rolls to midnight after 60 ticks
        do_reset();
        set_time(23, 59);
        chk("set_2359_state", bus.set_state, 3'd0);
        chk("set_2359", digits(), 24'h235900);
        chk("set_2359_pm", bus.pm, 1'b1);
        repeat (239) @(negedge clk);
        chk("pre_wrap", {digits(), 7'd0, bus.pm}, {24'h235959, 8'h01});
        @(negedge clk);
        chk("wrap", {digits(), 7'd0, bus.pm}, {24'h000000, 8'h00});

        // Hour wrap in SET_HOUR leaves minutes alone; no ticks while setting
        do_reset();
        set_time(23, 45);
        step(1, 0);
        step(0, 1);
        chk("hour_wrap", {5'd0, bus.set_state, digits()}, {8'h01, 24'h004500});
        seen = 0;
        repeat (12) begin
            seen += int'(bus.sec_tick);
            @(negedge clk);
        end
        chk("set_no_tick", seen, 0);

        // 12 h display
        do_reset();
        bus.fmt_12h = 1'b1;
        set_time(0, 10);
        chk("h12_0010", {digits(), 7'd0, bus.pm}, {24'h121000, 8'h00});
        do_reset();
        set_time(12, 0);
        chk("h12_1200", {digits(), 7'd0, bus.pm}, {24'h120000, 8'h01});
        do_reset();
        set_time(13, 5);
        chk("h12_1305", {digits(), 7'd0, bus.pm}, {24'h010500, 8'h01});
        #2 bus.fmt_12h = 1'b0;
        #1 chk("fmt_toggle", {bus.hour_10, bus.hour_01, 7'd0, bus.pm}, {8'h13, 8'h01});
        @(negedge clk);

        // mode+inc together, then asynchronous reset inside SET_MIN
        do_reset();
        step(1, 0);
        step(0, 1);
        step(1, 1);
        chk("mode_wins", {5'd0, bus.set_state, bus.hour_10, bus.hour_01}, {8'h02, 8'h01});
        step(0, 1);
        #2 clr_n = 1'b0;
        #1 chk("async_clr", {5'd0, bus.set_state, digits()}, {8'h00, 24'h000000});
        #1 clr_n = 1'b1;
        @(negedge clk);

`ifdef CLOCK_ALARM_EN
        // Alarm at 00:01 for 3 ticks
        do_reset();
        bus.alarm_on = 1'b1;
        set_alarm(0, 1);
        seen = 0;
        for (int n = 0; n <= 252; n++) begin
            if (n == 240) chk("alarm_pre", bus.alarm, 1'b0);
            if (n == 241) chk("alarm_rise", bus.alarm, 1'b1);
            if (n == 251) chk("alarm_hold", bus.alarm, 1'b1);
            if (n == 252) chk("alarm_fall", bus.alarm, 1'b0);
            if (bus.alarm && bus.sec_tick) seen++;
            if (n < 252) @(negedge clk);
        end
        chk("alarm_ticks", seen, c_ALARM_SECS);
        do_reset();
        set_alarm(0, 1);
        repeat (243) @(negedge clk);
        chk("alarm_mid", bus.alarm, 1'b1);
        bus.alarm_on = 1'b0;
        @(negedge clk);
        chk("alarm_off", bus.alarm, 1'b0);
`endif

        // Randomized run against the reference model
        bus.fmt_12h = 1'b0;
        aon = 1'b1;
`ifdef CLOCK_ALARM_EN
        bus.alarm_on = aon;
`endif
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            act = {bus.set_state, digits(), bus.pm, bus.sec_tick};
            chk($sformatf("rand%0d", n), act, m_expect());
`ifdef CLOCK_ALARM_EN
            chk($sformatf("rand_alarm%0d", n), bus.alarm, m_alarm);
`endif
            if (m_state == 0) begin
                mode = ($urandom_range(0, 149) == 0);
                inc  = ($urandom_range(0, 9) == 0);
            end else begin
                mode = ($urandom_range(0, 11) == 0);
                inc  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 39) == 0) bus.fmt_12h = ~bus.fmt_12h;
            if ($urandom_range(0, 199) == 0) aon = ~aon;
`ifdef CLOCK_ALARM_EN
            bus.alarm_on = aon;
`endif
            model_step(mode, inc, aon);
            step(mode, inc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_bcd_cfg.md
Name: clock_bcd_cfg

Overview:
- Parametrised successor of the fixed 24 h BCD time-of-day clock.
- Runs from a fast system clock through an internal 1 s prescaler, not from a dedicated 1 Hz clock.
- Adds an on-board set-mode state machine driven by two buttons, and runtime 12/24 h display selection.
- Sits between the debounced button block and the 7-segment display mux.

Parameters:
- CLK_DIV, 1, clk cycles per second; 1 means clk is already 1 Hz; prescaler width = clog2(CLK_DIV), minimum 1.
- ALARM_SECS, 60, alarm output duration in seconds; used only with CLOCK_ALARM_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clr_n  input  1  asynchronous active-low reset
- mode_btn  input  1  one-cycle pulse, already debounced; advances the set FSM
- inc_btn  input  1  one-cycle pulse, already debounced; increments the field selected in set mode
- fmt_12h  input  1  1 = 12 h display, 0 = 24 h display
- sec_01, sec_10, min_01, min_10, hour_01, hour_10  output  4 each  BCD display digits
- pm  output  1  high for internal hours 12..23, in both display formats
- sec_tick  output  1  one-cycle pulse at each second boundary, RUN state only
- set_state  output  3  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_AHOUR, 4 SET_AMIN
- alarm_on  input  1  alarm arm; port exists only with CLOCK_ALARM_EN
- alarm  output  1  alarm active; port exists only with CLOCK_ALARM_EN

Behaviour:
- Reset (clr_n low, asynchronous):
  - time 00:00:00, prescaler 0, state RUN.
  - sec_tick 0, pm 0, set_state 0.
  - With 24 h display all digits read 0; with fmt_12h=1 the hour digits read 12.
- Internal time is always 24 h BCD. Each field is a tens/units BCD pair; units wrap 9->0 with a carry into tens.
- Prescaler (RUN only):
  - Counts 0..CLK_DIV-1.
  - sec_tick=1 in the cycle the count equals CLK_DIV-1; the count then returns to 0.
  - CLK_DIV=1: sec_tick is high every cycle.
- Time update on sec_tick, registered, visible on the outputs the cycle after the tick:
  - sec 59->00 carries into min.
  - min 59->00 with sec carry carries into hour.
  - 23:59:59 -> 00:00:00.
- Set FSM, advanced by mode_btn:
  - RUN -> SET_HOUR -> SET_MIN -> (SET_AHOUR -> SET_AMIN, only with CLOCK_ALARM_EN) -> RUN.
- In any SET state:
  - Prescaler held at 0, time frozen, sec_tick 0.
  - inc_btn increments the selected field modulo its range (hour 23->00, min 59->00) with no carry into other fields.
- Leaving SET_MIN (or SET_AMIN) back to RUN: seconds cleared to 00 and prescaler restarted from 0, so the first tick comes CLK_DIV cycles later.
- mode_btn and inc_btn in the same cycle: mode wins, inc ignored.
- 12 h display (combinational from the registered time):
  - Internal 00 -> 12; 01..12 unchanged; 13..23 -> 01..11.
  - pm independent of fmt_12h.
  - fmt_12h may change at any time; display follows the same cycle.
- Reset during a set state returns to RUN with time 00:00:00; any partial edit is lost.

Optional Feature:
- Macro: CLOCK_ALARM_EN.
- Defined:
  - Alarm hour/min registers, reset to 00:00, edited in SET_AHOUR and SET_AMIN exactly like the time fields.
  - alarm_on and alarm ports present.
  - alarm rises the cycle after the time becomes hh:mm:00 equal to the alarm time, in RUN with alarm_on=1.
  - alarm stays high for ALARM_SECS sec_ticks, then falls.
  - alarm_on=0 or entering any SET state clears alarm the next cycle.
  - Reset clears alarm.
- Undefined:
  - No alarm registers or ports.
  - FSM wraps SET_MIN -> RUN; set_state never shows 3 or 4.

Test Plan:
1. CLK_DIV=4, release clr_n -> all digits 0, pm=0, set_state=0; sec_tick every 4th cycle; sec_01=1 one cycle after the first tick.
2. Set sequence: mode, 23x inc, mode, 59x inc, mode -> shows 23:59:00, set_state=0; after 60 ticks (240 clk) -> 00:00:00, pm falls 1->0.
3. In SET_HOUR at 23 with minutes 45, inc -> hour 00, minutes stay 45; no sec_tick while in set state.
4. fmt_12h=1: internal 00:10 -> hour digits 12, pm=0; 12:00 -> 12, pm=1; 13:05 -> 01, pm=1; toggle fmt_12h -> hour digits change the same cycle.
5. mode_btn and inc_btn in the same cycle in SET_HOUR -> state becomes SET_MIN, hour unchanged; clr_n pulse mid SET_MIN -> RUN, 00:00:00.
6. CLOCK_ALARM_EN, ALARM_SECS=3: alarm 00:01, alarm_on=1, run from 00:00:00 -> alarm high after the 60th tick for exactly 3 ticks; repeat with alarm_on dropped mid-alarm -> alarm low the next cycle.
